tree_adder_sequencer: RTL and testbench
=======================================

# tree_adder_sequencer

Time-multiplexes a single combinational `TreeAdder` across a long reduction. It accepts `NUM_CHUNKS` successive vectors of `NUM_TERMS` words over a valid/ready handshake and accumulates each vector's tree sum. It then presents one accumulated result on an output valid/ready handshake. It sits between the 3x3 window product stage and the output/requantisation stage of the convolution core and sums per-channel window products into one output pixel.

## Interface
- `WORD_WIDTH`, 8: width of each input term and of the `TreeAdder` sum.
- `NUM_TERMS`, 9: terms per chunk (one 3x3 window); passed to the internal `TreeAdder`.
- `NUM_CHUNKS`, 4: chunks accumulated per result; must be ≥1.
- `ACC_WIDTH`, `WORD_WIDTH+$clog2(NUM_CHUNKS)`: accumulator and result width; must be ≥ `WORD_WIDTH`.
- `CNT_WIDTH`, `$clog2(NUM_CHUNKS)` (minimum 1): chunk index width.

Ports:
- `i_clk`, in, 1: clock. All state changes on the rising edge.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_clear`, in, 1: synchronous abort of the current accumulation.
- `i_terms`, in, `WORD_WIDTH*NUM_TERMS`: chunk terms. Term k is at `[k*WORD_WIDTH +: WORD_WIDTH]`.
- `i_valid`, in, 1: `i_terms` is valid.
- `o_ready`, out, 1: the block can accept a chunk.
- `o_chunk_idx`, out, `CNT_WIDTH`: index of the next chunk to be accepted (0..`NUM_CHUNKS-1`).
- `o_sum`, out, `ACC_WIDTH`: accumulated result.
- `o_valid`, out, 1: `o_sum` is valid.
- `i_ready`, in, 1: downstream accepts `o_sum`.

## Operation
- **States:**
  - `S_ACCUM`: `o_ready=1`, `o_valid=0`.
  - `S_OUT`: `o_ready=0`, `o_valid=1`.
- **Chunk accept:** `i_valid && o_ready` at an edge.
- **Partial sum:** the `TreeAdder` output on `i_terms`, combinational. It is `WORD_WIDTH` wide and wraps modulo 2^`WORD_WIDTH`.
- **Zero-extension:** the partial sum is zero-extended to `ACC_WIDTH`.
- **Accumulation:** `acc = acc + partial`, modulo 2^`ACC_WIDTH`.
- **In `S_ACCUM`, on accept with `chunk_idx < NUM_CHUNKS-1`:**
  - `acc <= acc + partial`
  - `chunk_idx <= chunk_idx+1`
- **In `S_ACCUM`, on accept with `chunk_idx == NUM_CHUNKS-1`:**
  - `o_sum <= acc + partial`
  - `acc <= 0`, `chunk_idx <= 0`
  - go to `S_OUT`
- **No accept (`i_valid=0`):** state holds. Bubbles between chunks do not affect the result.
- **In `S_OUT`:**
  - `o_sum` is held stable.
  - `i_valid` and `i_terms` are ignored.
  - When `i_ready=1`, go to `S_ACCUM`.
- **`NUM_CHUNKS=1`:** every accept goes directly to `S_OUT`.
- **`i_clear=1` (highest synchronous priority, either state):**
  - `acc <= 0`, `chunk_idx <= 0`
  - go to `S_ACCUM`
  - a pending `o_sum` is dropped and `o_valid` falls
  - any chunk presented in the same cycle is discarded
- **`i_rst_n=0` (any time, including mid-accumulation or in `S_OUT`):** immediate return to `S_ACCUM`.
- **Reset values:** `o_ready=1`, `o_valid=0`, `o_sum=0`, `o_chunk_idx=0`, `acc=0`.
- **`o_sum` while `o_valid=0`:** retains its last value (0 after reset); it is not defined as meaningful.

## Timing
- **Latency:** `o_valid` rises on the edge that accepts the last chunk, i.e. it is visible the cycle after the last accept.
- **Output handshake:** completes on an edge with `o_valid && i_ready`. `o_ready` is 1 from the following cycle.
- **Throughput:** one result per `NUM_CHUNKS+1` cycles with `i_valid` and `i_ready` held high.
- **Ready/valid independence:**
  - `o_ready` and `o_valid` are registered state decodes with no combinational path from `i_valid`, `i_ready` or `i_clear`.
  - `o_ready` must not depend on `i_valid`, and `o_valid` must not depend on `i_ready`.
- **Critical path:** the `TreeAdder` plus the `ACC_WIDTH` adder in one cycle. No internal pipelining.

## Test plan
Defaults: `WORD_WIDTH=8`, `NUM_TERMS=9`, `NUM_CHUNKS=4`, `ACC_WIDTH=10`.

- **Reset:** assert `i_rst_n=0` for 3 cycles mid-stream, then release.
  - Required: `o_ready=1`, `o_valid=0`, `o_sum=0`, `o_chunk_idx=0`.
  - Required: no stale accumulation appears in the next result.
- **Back-to-back arithmetic series:** 4 chunks, each with terms 0..8 (partial 36), `i_valid` held high, `i_ready=1`.
  - Required: `o_chunk_idx` steps 0,1,2,3.
  - Required: `o_valid=1` with `o_sum=144` the cycle after the 4th accept.
  - Required: `o_ready=1` again one cycle later.
- **Backpressure:** as the back-to-back case, with `i_ready=0` for 5 cycles and `i_valid=1` carrying junk terms.
  - Required: `o_sum=144` and `o_valid=1` stable, `o_ready=0`, no junk accumulated.
  - Required: after `i_ready=1`, the next 4 chunks of all 1s give `o_sum=36`.
- **Wrap and bubbles:** 4 chunks of all 8'hFF, with 2 idle cycles between chunks.
  - Required: each partial is 247 (2295 mod 256).
  - Required: `o_sum=988`, the same as the no-bubble run.
- **Clear mid-accumulation:** accept 2 chunks of 0..8, then pulse `i_clear` together with `i_valid` on a third chunk.
  - Required: `o_chunk_idx=0` and the third chunk is discarded.
  - Required: 4 further chunks of all 2s give `o_sum=72`.
- **Clear in `S_OUT`:** pulse `i_clear` while `o_valid=1`.
  - Required: `o_valid=0` and `o_ready=1` the next cycle; no handshake occurs.

Source files
------------

// File: rtl/tree_adder_sequencer.sv
// Time-multiplexes one combinational tree adder over NUM_CHUNKS input vectors
// and presents the accumulated sum on a valid/ready output handshake.

module tree_adder #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_TERMS  = 9
) (
  input  logic [WORD_WIDTH*NUM_TERMS-1:0] terms,
  output logic [WORD_WIDTH-1:0]           sum
);

  localparam int LEVELS = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 0;
  localparam int LEAVES = 1 << LEVELS;

  // Heap-ordered binary tree: node i has children 2i+1 and 2i+2, leaves padded with zero.
  logic [WORD_WIDTH-1:0] node [2*LEAVES-1];

  always_comb begin
    for (int i = 0; i < 2*LEAVES-1; i++) node[i] = '0;
    for (int k = 0; k < NUM_TERMS; k++) node[LEAVES-1+k] = terms[k*WORD_WIDTH +: WORD_WIDTH];
    for (int i = LEAVES-2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
    sum = node[0];
  end

endmodule

// state   | meaning
// S_ACCUM | accepting chunks, accumulating tree sums (o_ready=1)
// S_OUT   | holding the finished result for downstream (o_valid=1)
module tree_adder_sequencer #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_TERMS  = 9,
  parameter int NUM_CHUNKS = 4,
  parameter int ACC_WIDTH  = WORD_WIDTH + $clog2(NUM_CHUNKS),
  parameter int CNT_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_clear,
  input  logic [WORD_WIDTH*NUM_TERMS-1:0] i_terms,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic [CNT_WIDTH-1:0]            o_chunk_idx,
  output logic [ACC_WIDTH-1:0]            o_sum,
  output logic                            o_valid,
  input  logic                            i_ready
);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_OUT   = 1'b1;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_CHUNKS - 1);

  logic [0:0]            state;
  logic [ACC_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]  chunk_idx;
  logic [WORD_WIDTH-1:0] partial;
  logic [ACC_WIDTH-1:0]  acc_next;

  tree_adder #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_TERMS  (NUM_TERMS)
  ) u_tree (
    .terms (i_terms),
    .sum   (partial)
  );

  assign acc_next = acc + ACC_WIDTH'(partial);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_ACCUM;
      acc       <= '0;
      chunk_idx <= '0;
      o_sum     <= '0;
    end else if (i_clear) begin
      // o_sum keeps its last value; only o_valid falls with the state change.
      state     <= S_ACCUM;
      acc       <= '0;
      chunk_idx <= '0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (i_valid) begin
            if (chunk_idx == LAST_IDX) begin
              o_sum     <= acc_next;
              acc       <= '0;
              chunk_idx <= '0;
              state     <= S_OUT;
            end else begin
              acc       <= acc_next;
              chunk_idx <= chunk_idx + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (i_ready) state <= S_ACCUM;
        end
        default: state <= S_ACCUM;
      endcase
    end
  end

  assign o_ready     = (state == S_ACCUM);
  assign o_valid     = (state == S_OUT);
  assign o_chunk_idx = chunk_idx;

endmodule

// File: tb/tb_tree_adder_sequencer.sv
// Bench for tree_adder_sequencer: directed scenarios plus random traffic
// checked against a queue-based reference of accepted chunk partial sums.

module tb_tree_adder_sequencer;

  localparam int W  = 8;
  localparam int N  = 9;
  localparam int C  = 4;
  localparam int AW = 10;
  localparam int CW = 2;

  logic              i_clk   = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_clear = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_ready = 1'b0;
  logic [W*N-1:0]    i_terms = '0;
  logic              o_ready;
  logic              o_valid;
  logic [CW-1:0]     o_chunk_idx;
  logic [AW-1:0]     o_sum;

  tree_adder_sequencer #(
    .WORD_WIDTH (W),
    .NUM_TERMS  (N),
    .NUM_CHUNKS (C)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_clear),
    .i_terms     (i_terms),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_chunk_idx (o_chunk_idx),
    .o_sum       (o_sum),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // reference: partial sums of chunks accepted so far in the current result
  int q[$];
  bit m_out = 1'b0;
  int m_sum = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int partial_of(input logic [W*N-1:0] t);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(t[k*W +: W]);
    return s % 256;
  endfunction

  function automatic logic [W*N-1:0] fill(input logic [W-1:0] b);
    logic [W*N-1:0] t;
    for (int k = 0; k < N; k++) t[k*W +: W] = b;
    return t;
  endfunction

  function automatic logic [W*N-1:0] series();
    logic [W*N-1:0] t;
    for (int k = 0; k < N; k++) t[k*W +: W] = W'(k);
    return t;
  endfunction

  function automatic logic [W*N-1:0] rand_terms();
    logic [W*N-1:0] t;
    for (int k = 0; k < N; k++) t[k*W +: W] = W'($urandom_range(0, 255));
    return t;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'(!m_out));
    check({tag, "_valid"}, 32'(o_valid), 32'(m_out));
    check({tag, "_idx"},   32'(o_chunk_idx), 32'(q.size()));
    check({tag, "_sum"},   32'(o_sum), 32'(m_sum));
  endtask

  task automatic cycle(input bit v, input logic [W*N-1:0] t, input bit r, input bit c, input string tag);
    i_valid = v;
    i_terms = t;
    i_ready = r;
    i_clear = c;
    @(posedge i_clk);
    if (c) begin
      q.delete();
      m_out = 1'b0;
    end else if (!m_out) begin
      if (v) begin
        q.push_back(partial_of(t));
        if (q.size() == C) begin
          int s;
          s = 0;
          foreach (q[j]) s += q[j];
          m_sum = s % 1024;
          q.delete();
          m_out = 1'b1;
        end
      end
    end else if (r) begin
      m_out = 1'b0;
    end
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    i_rst_n = 1'b0;
    q.delete();
    m_out = 1'b0;
    m_sum = 0;
    #1;
    compare_all({tag, "_inrst"});
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    compare_all({tag, "_post"});
  endtask

  initial begin
    logic [W*N-1:0] ar;
    ar = series();

    repeat (2) @(posedge i_clk);
    #1;
    compare_all("rst_init");
    i_rst_n = 1'b1;

    // back-to-back arithmetic series
    for (int i = 0; i < C; i++) begin
      check("series_idx_step", 32'(o_chunk_idx), 32'(i));
      cycle(1'b1, ar, 1'b1, 1'b0, "series");
    end
    check("series_sum_144", 32'(o_sum), 32'd144);
    check("series_valid", 32'(o_valid), 32'd1);
    cycle(1'b1, ar, 1'b1, 1'b0, "series_hs");
    check("series_ready_back", 32'(o_ready), 32'd1);

    // backpressure with junk terms presented while holding
    for (int i = 0; i < C; i++) cycle(1'b1, ar, 1'b1, 1'b0, "bp_fill");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rand_terms(), 1'b0, 1'b0, "bp_hold");
      check("bp_hold_sum", 32'(o_sum), 32'd144);
    end
    cycle(1'b1, rand_terms(), 1'b1, 1'b0, "bp_hs");
    for (int i = 0; i < C; i++) cycle(1'b1, fill(8'd1), 1'b1, 1'b0, "bp_ones");
    check("bp_ones_sum_36", 32'(o_sum), 32'd36);
    cycle(1'b0, '0, 1'b1, 1'b0, "bp_ones_hs");

    // wrap with bubbles
    for (int i = 0; i < C; i++) begin
      cycle(1'b1, fill(8'hFF), 1'b1, 1'b0, "wrap");
      if (i < C-1) repeat (2) cycle(1'b0, fill(8'hFF), 1'b1, 1'b0, "wrap_bubble");
    end
    check("wrap_sum_988", 32'(o_sum), 32'd988);
    cycle(1'b0, '0, 1'b1, 1'b0, "wrap_hs");

    // reset mid-accumulation, then no stale accumulation
    cycle(1'b1, fill(8'd7), 1'b1, 1'b0, "mrst_pre");
    cycle(1'b1, fill(8'd7), 1'b1, 1'b0, "mrst_pre");
    do_reset("mrst");
    check("mrst_sum_zero", 32'(o_sum), 32'd0);
    for (int i = 0; i < C; i++) cycle(1'b1, ar, 1'b1, 1'b0, "mrst_after");
    check("mrst_sum_144", 32'(o_sum), 32'd144);

    // reset while holding a result
    do_reset("orst");
    check("orst_valid", 32'(o_valid), 32'd0);

    // clear mid-accumulation discards the concurrent chunk
    cycle(1'b1, ar, 1'b0, 1'b0, "clr_pre");
    cycle(1'b1, ar, 1'b0, 1'b0, "clr_pre");
    cycle(1'b1, ar, 1'b0, 1'b1, "clr_pulse");
    check("clr_idx_zero", 32'(o_chunk_idx), 32'd0);
    for (int i = 0; i < C; i++) cycle(1'b1, fill(8'd2), 1'b0, 1'b0, "clr_twos");
    check("clr_sum_72", 32'(o_sum), 32'd72);

    // clear while a result is pending
    cycle(1'b0, '0, 1'b0, 1'b1, "clr_out");
    check("clr_out_valid", 32'(o_valid), 32'd0);
    check("clr_out_ready", 32'(o_ready), 32'd1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 150) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cycle($urandom_range(0, 3) != 0, rand_terms(), $urandom_range(0, 2) != 0,
              $urandom_range(0, 40) == 0, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
